// File: rtl/trace_pkg.sv
// Shared definitions for the trace recorder: record layout, event codes,
// controller states and the default buffer depth.
package trace_pkg;

    localparam int unsigned TRACE_DEPTH = 256;

    // Record field widths
    localparam int unsigned TYPE_W  = 3;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLAGS_W = 2;
    localparam int unsigned REC_W   = TYPE_W + ADDR_W + DATA_W + FLAGS_W;

    // Record field offsets, type in the MSBs and flags in the LSBs
    localparam int unsigned FLAGS_LSB = 0;
    localparam int unsigned DATA_LSB  = FLAGS_LSB + FLAGS_W;
    localparam int unsigned ADDR_LSB  = DATA_LSB + DATA_W;
    localparam int unsigned TYPE_LSB  = ADDR_LSB + ADDR_W;

    typedef enum logic [TYPE_W-1:0] {
        EvFetch = 3'd0,
        EvRead  = 3'd1,
        EvWrite = 3'd2,
        EvIrq   = 3'd3,
        EvMark  = 3'd4
    } ev_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRecord,
        StDumpRd,
        StDumpWait,
        StDumpOut
    } trace_state_e;

    // Pack one bus event into a RAM record
    function automatic logic [REC_W-1:0] pack_record(
        input logic [TYPE_W-1:0]  ev_type,
        input logic [ADDR_W-1:0]  ev_addr,
        input logic [DATA_W-1:0]  ev_data,
        input logic [FLAGS_W-1:0] ev_flags
    );
        logic [REC_W-1:0] rec;
        rec                          = '0;
        rec[TYPE_LSB  +: TYPE_W]     = ev_type;
        rec[ADDR_LSB  +: ADDR_W]     = ev_addr;
        rec[DATA_LSB  +: DATA_W]     = ev_data;
        rec[FLAGS_LSB +: FLAGS_W]    = ev_flags;
        return rec;
    endfunction

endpackage

// File: rtl/trace_ptr.sv
// Modulo-DEPTH up-counter with synchronous clear, load and a wrap flag
// that pulses on the increment taking the pointer from DEPTH-1 back to 0.
module trace_ptr
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH,
    parameter int unsigned PTR_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr,
    output logic             wrap
);

    logic [PTR_W-1:0] ptr_d, ptr_q;
    logic             at_top;

    assign at_top = (ptr_q == PTR_W'(DEPTH - 1));

    // Next pointer: clear beats load beats increment
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = at_top ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = inc && at_top && !clr && !load;

endmodule

// File: rtl/trace_recorder.sv
// Trace recorder: packs bus events into records, writes them to sequential
// trace RAM addresses, and streams the capture back out on a valid/ready port.
// Build option TRACE_WRAP_EN: defined selects a circular buffer that
// overwrites the oldest record when full; undefined stops (drops) on full.
module trace_recorder
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH      = TRACE_DEPTH,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = REC_W
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  ev_valid,
    input  logic [2:0]            ev_type,
    input  logic [15:0]           ev_addr,
    input  logic [15:0]           ev_data,
    input  logic [1:0]            ev_flags,
    output logic                  ram_clr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    input  logic                  dump_req,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_state_e          state_d, state_q;
    logic                  full_d, full_q;
    logic                  ovf_d, ovf_q;
    logic [DATA_WIDTH-1:0] dump_data_d, dump_data_q;

    logic [PTR_W-1:0]      wr_ptr, rd_ptr, newest, dump_start;
    logic                  wr_en, wr_wrap, wr_allowed, has_data;
    logic                  dump_go, rd_inc, is_last;
    logic                  unused_rd_wrap;

`ifdef TRACE_WRAP_EN
    // Circular buffer: always write; once full the oldest record sits at wr_ptr
    assign wr_allowed = 1'b1;
    assign dump_start = full_q ? wr_ptr : '0;
`else
    // Stop-on-full: writes cease at DEPTH records, oldest is always entry 0
    assign wr_allowed = !full_q;
    assign dump_start = '0;
`endif

    assign wr_en    = (state_q == StRecord) && ev_valid && wr_allowed;
    assign has_data = full_q || (wr_ptr != '0);
    assign dump_go  = (state_q == StIdle) && !start && dump_req && has_data;

    // Newest record is the one just behind wr_ptr in both buffer modes
    assign newest  = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign is_last = (rd_ptr == newest);
    assign rd_inc  = (state_q == StDumpOut) && dump_ready && !is_last;

    trace_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk      (clk),
        .clr_n    (clr_n),
        .clr      (state_q == StClear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wr_en),
        .ptr      (wr_ptr),
        .wrap     (wr_wrap)
    );

    // End of dump comes from the newest-record compare, so rd wrap is not needed
    trace_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk      (clk),
        .clr_n    (clr_n),
        .clr      (1'b0),
        .load     (dump_go),
        .load_val (dump_start),
        .inc      (rd_inc),
        .ptr      (rd_ptr),
        .wrap     (unused_rd_wrap)
    );

    // Next-state logic for the controller, the full/overflow flags and dump data
    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        dump_data_d = dump_data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end else if (dump_go) begin
                    state_d = StDumpRd;
                end
            end
            StClear: begin
                full_d  = 1'b0;
                ovf_d   = 1'b0;
                state_d = StRecord;
            end
            StRecord: begin
                // Any event arriving while full is either dropped or overwrites
                if (ev_valid && full_q) begin
                    ovf_d = 1'b1;
                end
                if (wr_wrap) begin
                    full_d = 1'b1;
                end
                if (start) begin
                    state_d = StClear;
                end else if (stop) begin
                    state_d = StIdle;
                end
            end
            StDumpRd: begin
                state_d = StDumpWait;
            end
            StDumpWait: begin
                dump_data_d = ram_rd_data;
                state_d     = StDumpOut;
            end
            StDumpOut: begin
                if (dump_ready) begin
                    state_d = is_last ? StIdle : StDumpRd;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller and flag registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign ram_clr     = (state_q == StClear);
    assign ram_we      = wr_en;
    assign ram_wr_addr = ADDR_WIDTH'(wr_ptr);
    assign ram_wr_data = wr_en ? pack_record(ev_type, ev_addr, ev_data, ev_flags) : '0;
    assign ram_re      = (state_q == StDumpRd) || (state_q == StDumpWait) ||
                         (state_q == StDumpOut);
    assign ram_rd_addr = ADDR_WIDTH'(rd_ptr);

    assign dump_valid  = (state_q == StDumpOut);
    assign dump_data   = dump_data_q;
    assign dump_last   = dump_valid && is_last;

    // Stored records equal wr_ptr until the buffer first fills, then saturate
    assign count       = full_q ? ADDR_WIDTH'(DEPTH) : ADDR_WIDTH'(wr_ptr);
    assign overflow    = ovf_q;
    assign busy        = (state_q != StIdle);

endmodule
